mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester SRAM arbiter: a four-state Moore FSM grants one requester at a
// time, runs a single SRAM cycle for it and reports completion with a pulse.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              freeze,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              sram_en,
  output logic              write_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_ACCESS,
    S_COMPLETE
  } state_e;

  state_e            state_q, state_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_served_q, last_served_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              win;

  // A lone requester always wins; on a tie the one not served last goes first.
  assign win = (req0 && req1) ? ~last_served_q : req1;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    id_d          = id_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    last_served_d = last_served_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;

    case (state_q)
      S_IDLE: begin
        if (!freeze && (req0 || req1)) begin
          state_d = S_GRANT;
          id_d    = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
        end
      end
      S_GRANT: state_d = S_ACCESS;
      S_ACCESS: begin
        state_d = S_COMPLETE;
        if (!we_q) begin
          if (id_q) rdata1_d = sram_rdata;
          else      rdata0_d = sram_rdata;
        end
      end
      S_COMPLETE: begin
        state_d       = S_IDLE;
        last_served_d = id_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      id_q          <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      last_served_q <= 1'b1;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      last_served_q <= last_served_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
    end
  end

  // Outputs depend only on registered state, so reset reaches them at once.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;
    sram_en  = 1'b1;
    write_en = 1'b1;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_GRANT: begin
        gnt0 = ~id_q;
        gnt1 = id_q;
      end
      S_ACCESS: begin
        sram_en  = 1'b0;
        write_en = ~we_q;
      end
      S_COMPLETE: begin
        done0 = ~id_q;
        done1 = id_q;
      end
      default: ;
    endcase
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural SRAM, transaction-level reference model,
// directed scenarios and randomized traffic.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, freeze;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, busy, sram_en, write_en;
  logic [DW-1:0] rdata0, rdata1, sram_wdata, sram_rdata;
  logic [AW-1:0] sram_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory contents, per-requester read data, last served.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] m_rdata0, m_rdata1;
  int            m_last;

  logic [DW-1:0] sram_mem [256];
  logic          mem_ready = 1'b0;

  wire [6:0] ctl = {gnt0, gnt1, done0, done1, busy, sram_en, write_en};
  localparam logic [6:0] CTL_IDLE = 7'b0000011;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .freeze(freeze),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .sram_en(sram_en), .write_en(write_en),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .busy(busy)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 8'h12) ? 16'hBEEF : DW'(i * 40503 + 90);
  endfunction

  // Behavioural SRAM: asynchronous read, write on the clock edge while enabled.
  assign sram_rdata = sram_mem[sram_addr];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (!sram_en && !write_en) begin
      sram_mem[sram_addr] <= sram_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    req0   = 1'($urandom_range(1));
    req1   = 1'($urandom_range(1));
    we0    = 1'($urandom_range(1));
    we1    = 1'($urandom_range(1));
    addr0  = AW'($urandom);
    addr1  = AW'($urandom);
    wdata0 = DW'($urandom);
    wdata1 = DW'($urandom);
    freeze = 1'($urandom_range(1));
  endtask

  task automatic model_reset();
    m_last   = 1;
    m_rdata0 = '0;
    m_rdata1 = '0;
  endtask

  // Drives one request set at an idle sampling edge and checks the whole
  // transaction (or its absence) against the model; returns with DUT idle.
  task automatic run_txn(input string tag, input logic r0, input logic r1,
                         input logic w0, input logic w1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic frz);
    logic go, win, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [6:0] exp_ctl;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; freeze = frz;
    go  = !frz && (r0 || r1);
    win = (r0 && r1) ? (m_last == 0) : r1;
    we  = win ? w1 : w0;
    a   = win ? a1 : a0;
    d   = win ? d1 : d0;
    tick();
    n_checks++;
    if (!go) begin
      if (ctl !== CTL_IDLE) begin
        n_fail++;
        $display("FAIL %s no_grant: ctl=%b expected %b", tag, ctl, CTL_IDLE);
      end
      return;
    end
    exp_ctl = win ? 7'b0100111 : 7'b1000111;
    if (ctl !== exp_ctl) begin
      n_fail++;
      $display("FAIL %s grant: ctl=%b expected %b", tag, ctl, exp_ctl);
    end
    scramble();
    tick();
    exp_ctl = {4'b0000, 1'b1, 1'b0, ~we};
    n_checks++;
    if (ctl !== exp_ctl || sram_addr !== a) begin
      n_fail++;
      $display("FAIL %s access: ctl=%b addr=%h expected ctl=%b addr=%h",
               tag, ctl, sram_addr, exp_ctl, a);
    end
    if (we) begin
      n_checks++;
      if (sram_wdata !== d) begin
        n_fail++;
        $display("FAIL %s wdata: got %h expected %h", tag, sram_wdata, d);
      end
    end
    scramble();
    tick();
    if (we) ref_mem[a] = d;
    else if (win) m_rdata1 = ref_mem[a];
    else m_rdata0 = ref_mem[a];
    m_last  = win ? 1 : 0;
    exp_ctl = win ? 7'b0001111 : 7'b0010111;
    n_checks++;
    if (ctl !== exp_ctl || rdata0 !== m_rdata0 || rdata1 !== m_rdata1) begin
      n_fail++;
      $display("FAIL %s complete: ctl=%b rdata0=%h rdata1=%h expected ctl=%b rdata0=%h rdata1=%h",
               tag, ctl, rdata0, rdata1, exp_ctl, m_rdata0, m_rdata1);
    end
    scramble();
    tick();
    n_checks++;
    if (ctl !== CTL_IDLE) begin
      n_fail++;
      $display("FAIL %s return_idle: ctl=%b expected %b", tag, ctl, CTL_IDLE);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b1; freeze = 1'b0;
    addr0 = 8'h33; addr1 = 8'h44; wdata0 = 16'h1111; wdata1 = 16'h2222;
    tick();
    tick();
    n_checks++;
    if (ctl !== CTL_IDLE || sram_addr !== '0 || sram_wdata !== '0 ||
        rdata0 !== '0 || rdata1 !== '0) begin
      n_fail++;
      $display("FAIL reset_values: ctl=%b addr=%h wdata=%h r0=%h r1=%h expected ctl=%b and zeros",
               ctl, sram_addr, sram_wdata, rdata0, rdata1, CTL_IDLE);
    end
    req0 = 1'b0; req1 = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if (ctl !== CTL_IDLE) begin
      n_fail++;
      $display("FAIL reset_release_idle: ctl=%b expected %b", ctl, CTL_IDLE);
    end
  endtask

  task automatic test_single_read();
    run_txn("single_read", 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 8'h00, 16'h0, 16'h0, 1'b0);
    n_checks++;
    if (rdata0 !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL single_read_data: rdata0=%h expected beef", rdata0);
    end
  endtask

  task automatic test_single_write();
    run_txn("single_write", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h40, 16'h0, 16'h1234, 1'b0);
    run_txn("write_readback", 1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 8'h00, 16'h0, 16'h0, 1'b0);
    n_checks++;
    if (rdata0 !== 16'h1234) begin
      n_fail++;
      $display("FAIL write_readback_data: rdata0=%h expected 1234", rdata0);
    end
  endtask

  task automatic test_contention();
    logic [7:0] seq;
    int n_gnt, n_done, n_both;
    apply_reset();
    seq = '0; n_gnt = 0; n_done = 0; n_both = 0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; freeze = 1'b0;
    addr0 = 8'h21; addr1 = 8'h87;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (gnt0 && gnt1) n_both++;
      if (gnt0) begin seq = {seq[5:0], 2'b01}; n_gnt++; end
      if (gnt1) begin seq = {seq[5:0], 2'b10}; n_gnt++; end
      if (done0 || done1) n_done++;
    end
    req0 = 1'b0; req1 = 1'b0;
    m_rdata0 = ref_mem[8'h21];
    m_rdata1 = ref_mem[8'h87];
    m_last   = 1;
    n_checks++;
    if (seq !== 8'h66 || n_gnt != 4) begin
      n_fail++;
      $display("FAIL contention_order: seq=%h grants=%0d expected seq=66 grants=4", seq, n_gnt);
    end
    n_checks++;
    if (n_done != 4 || n_both != 0) begin
      n_fail++;
      $display("FAIL contention_done: dones=%0d both_gnt=%0d expected 4 and 0", n_done, n_both);
    end
    n_checks++;
    if (rdata0 !== m_rdata0 || rdata1 !== m_rdata1) begin
      n_fail++;
      $display("FAIL contention_rdata: r0=%h r1=%h expected %h %h", rdata0, rdata1, m_rdata0, m_rdata1);
    end
  endtask

  task automatic test_freeze();
    int bad;
    bad = 0;
    req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; addr0 = 8'h05; freeze = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (ctl !== CTL_IDLE) begin
        n_fail++;
        $display("FAIL freeze_hold cycle %0d: ctl=%b expected %b", c, ctl, CTL_IDLE);
      end
    end
    run_txn("freeze_release", 1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; addr0 = 8'h99; freeze = 1'b0;
    tick();
    tick();
    n_checks++;
    if (sram_en !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_setup: sram_en=%b expected 0", sram_en);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (ctl !== CTL_IDLE || rdata0 !== '0 || rdata1 !== '0) begin
      n_fail++;
      $display("FAIL abort_immediate: ctl=%b r0=%h r1=%h expected ctl=%b and zeros",
               ctl, rdata0, rdata1, CTL_IDLE);
    end
    tick();
    n_checks++;
    if (ctl !== CTL_IDLE) begin
      n_fail++;
      $display("FAIL abort_no_done: ctl=%b expected %b", ctl, CTL_IDLE);
    end
    #3 reset = 1'b0;
    model_reset();
    run_txn("after_abort", 1'b1, 1'b0, 1'b0, 1'b0, 8'h99, 8'h00, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_freeze_mid_access();
    logic win;
    logic [6:0] exp_ctl;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; freeze = 1'b0;
    addr0 = 8'h0A; addr1 = 8'hB0;
    win = (m_last == 0);
    tick();
    exp_ctl = win ? 7'b0100111 : 7'b1000111;
    n_checks++;
    if (ctl !== exp_ctl) begin
      n_fail++;
      $display("FAIL freeze_mid_grant: ctl=%b expected %b", ctl, exp_ctl);
    end
    freeze = 1'b1;
    tick();
    tick();
    if (win) m_rdata1 = ref_mem[8'hB0];
    else m_rdata0 = ref_mem[8'h0A];
    m_last  = win ? 1 : 0;
    exp_ctl = win ? 7'b0001111 : 7'b0010111;
    n_checks++;
    if (ctl !== exp_ctl || rdata0 !== m_rdata0 || rdata1 !== m_rdata1) begin
      n_fail++;
      $display("FAIL freeze_mid_done: ctl=%b r0=%h r1=%h expected ctl=%b r0=%h r1=%h",
               ctl, rdata0, rdata1, exp_ctl, m_rdata0, m_rdata1);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (ctl !== CTL_IDLE) begin
        n_fail++;
        $display("FAIL freeze_mid_blocked cycle %0d: ctl=%b expected %b", c, ctl, CTL_IDLE);
      end
    end
    req0 = 1'b0; req1 = 1'b0; freeze = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      run_txn($sformatf("random_%0d", n),
              1'($urandom_range(1)), 1'($urandom_range(1)),
              1'($urandom_range(1)), 1'($urandom_range(1)),
              AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
              ($urandom_range(7) == 0));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_freeze();
    test_reset_mid_access();
    test_freeze_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
